run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Sequences one program run of the core and arbitrates the data memory between a host port and the core.
- Holds the core in reset while idle; the host preloads operands into dat_mem.
- On start, releases the core and hands dat_mem to the core's load/store path; latches done or a watchdog timeout.
- Returns dat_mem to the host for result readout. Sits between the core top, dat_mem and the test harness.

Parameters:
- DW, 8, data memory word width
- AW, 8, data memory address width
- CYC_W, 16, run cycle counter width
- MAX_CYCLES, 16'hFFFF, watchdog limit in clk cycles spent in RUN

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  host run request, sampled in IDLE/DONE/TIMEOUT
- host_req  in  1  host memory access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host_rdata valid (one cycle after a granted read)
- host_rdata  out  DW  registered read data
- core_reset  out  1  drives core PC reset, active high
- core_done  in  1  core PC done flag
- core_we  in  1  core data memory write enable
- core_addr  in  AW  core data memory address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  mem_rdata passed through to the core
- mem_we  out  1  to dat_mem wr_en
- mem_addr  out  AW  to dat_mem addr
- mem_wdata  out  DW  to dat_mem dat_in
- mem_rdata  in  DW  dat_mem dat_out, combinational read
- busy  out  1  state is LAUNCH or RUN
- run_done  out  1  sticky, run completed
- run_timeout  out  1  sticky, watchdog expired
- cycle_cnt  out  CYC_W  cycles spent in last/current RUN

Behaviour:
- States: IDLE, LAUNCH, RUN, DONE, TIMEOUT. Reset (async on reset_n low) -> IDLE.
- Reset values: all outputs 0, except core_reset=1. Asserting reset_n mid-RUN aborts immediately; memory contents are untouched.
- IDLE/DONE/TIMEOUT (host owns memory):
  - mem_* driven from host_*, mem_we = host_req & host_we & host_gnt.
  - host_gnt = host_req & ~start (combinational).
  - A granted read registers mem_rdata into host_rdata; host_rvalid=1 the next cycle only.
  - core_reset=1.
- start in IDLE/DONE/TIMEOUT -> LAUNCH:
  - clears run_done, run_timeout and cycle_cnt.
  - start has priority over a simultaneous host_req (gnt=0 that cycle, no memory write).
- LAUNCH: one cycle. core_reset=1, memory muxed to the core, mem_we=0. -> RUN.
- RUN:
  - core_reset=0; mem_we=core_we, mem_addr=core_addr, mem_wdata=core_wdata.
  - host_gnt=0; a held host_req stalls without error.
  - cycle_cnt increments every cycle, saturating at all-ones.
- Exit from RUN:
  - core_done=1 -> DONE, run_done=1. The core write in that same cycle still commits.
  - Else if cycle_cnt == MAX_CYCLES-1 -> TIMEOUT, run_timeout=1.
  - core_done wins over a simultaneous timeout.
- core_rdata = mem_rdata in all states; the core ignores it outside RUN.
- start while in LAUNCH or RUN is ignored.
- busy = (LAUNCH | RUN).

Optional Feature:
- Macro: RUN_CTRL_WR_COUNT_EN.
- Defined: adds output core_wr_cnt [CYC_W-1:0].
  - Counts mem_we cycles in RUN, saturating.
  - Cleared on the transition into LAUNCH; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- run_ctrl_pkg holds:
  - state enum run_state_t {IDLE, LAUNCH, RUN, DONE, TIMEOUT}.
  - Default constants RC_DW=8, RC_AW=8, RC_CYC_W=16.
- One natural sub-module: run_ctrl_mem_mux, the combinational host/core selection of mem_we/addr/wdata keyed on state.
- FSM, counters and host read register stay in run_ctrl.

Test Plan:
- Preload:
  - In IDLE, host writes 8'hA5 to addr 8'h10, then reads 8'h10.
  - host_gnt=1 on both; host_rvalid=1 with host_rdata=8'hA5 one cycle after the read; core_reset=1 throughout.
- Normal run:
  - Pulse start; core writes 8'h3C to 8'h20, then core_done rises 5 cycles after RUN entry.
  - Sequence LAUNCH->RUN->DONE; run_done=1; cycle_cnt=5; host read of 8'h20 returns 8'h3C.
- Stall: host_req=1, host_we=1 held during RUN -> host_gnt=0 and no host write lands; gnt=1 on the first DONE cycle.
- Watchdog:
  - MAX_CYCLES=8, core_done never rises -> TIMEOUT after 8 RUN cycles; run_timeout=1; run_done=0.
  - With core_done=1 on the 8th cycle instead -> DONE.
- Priority/abort:
  - start and host_req (write 8'hFF to 8'h00) in the same IDLE cycle -> gnt=0, 8'h00 unchanged, LAUNCH entered.
  - reset_n low mid-RUN -> IDLE immediately, core_reset=1.
- Optional (RUN_CTRL_WR_COUNT_EN): 3 core writes in a run -> core_wr_cnt=3; a second start clears it to 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default widths for the run controller slice.
// Imported by run_ctrl and run_ctrl_mem_mux.
package run_ctrl_pkg;

  localparam int RC_DW    = 8;
  localparam int RC_AW    = 8;
  localparam int RC_CYC_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Plain-vector aliases so state registers stay legacy-compatible logic vectors.
  localparam logic [2:0] ST_IDLE    = 3'(IDLE);
  localparam logic [2:0] ST_LAUNCH  = 3'(LAUNCH);
  localparam logic [2:0] ST_RUN     = 3'(RUN);
  localparam logic [2:0] ST_DONE    = 3'(DONE);
  localparam logic [2:0] ST_TIMEOUT = 3'(TIMEOUT);

  function automatic logic host_owns(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/run_ctrl_mem_mux.sv
// Combinational selection of the data memory port between host and core,
// keyed on the run controller state.
module run_ctrl_mem_mux
  import run_ctrl_pkg::*;
#(
  parameter int DW = RC_DW,
  parameter int AW = RC_AW
) (
  input  logic [2:0]    state,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_gnt,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  // Route the memory port to its owner; LAUNCH presents the core address but never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        mem_we    = host_req & host_we & host_gnt;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      ST_LAUNCH: begin
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      ST_RUN: begin
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
    endcase
  end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset while the host owns dat_mem, launches a run,
// and latches done/watchdog status. Optional core write counter under RUN_CTRL_WR_COUNT_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int               DW         = RC_DW,
  parameter int               AW         = RC_AW,
  parameter int               CYC_W      = RC_CYC_W,
  parameter logic [CYC_W-1:0] MAX_CYCLES = {CYC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  output logic             core_reset,
  input  logic             core_done,
  input  logic             core_we,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdata,
  output logic [DW-1:0]    core_rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             run_done,
  output logic             run_timeout,
  output logic [CYC_W-1:0] cycle_cnt
`ifdef RUN_CTRL_WR_COUNT_EN
  ,
  output logic [CYC_W-1:0] core_wr_cnt
`endif
);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             core_reset_r;
  logic             busy_r;
  logic             run_done_r;
  logic             run_timeout_r;
  logic [CYC_W-1:0] cycle_cnt_r;
  logic             host_rvalid_r;
  logic [DW-1:0]    host_rdata_r;
  logic             host_owns_s;
  logic             host_gnt_s;
  logic             host_rd_s;
  logic             launch_s;
  logic             timeout_hit_s;
  logic             mem_we_s;

  assign host_owns_s   = host_owns(state_r);
  // start outranks a same-cycle host access so a launch never races a host write.
  assign host_gnt_s    = host_owns_s & host_req & ~start;
  assign host_rd_s     = host_gnt_s & ~host_we;
  assign launch_s      = host_owns_s & start;
  assign timeout_hit_s = (cycle_cnt_r == (MAX_CYCLES - CYC_W'(1)));

  // Next-state decode; core_done is checked before the watchdog so it wins a tie.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) state_nxt_s = ST_LAUNCH;
        else       state_nxt_s = state_r;
      end
      ST_LAUNCH: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (core_done)          state_nxt_s = ST_DONE;
        else if (timeout_hit_s) state_nxt_s = ST_TIMEOUT;
        else                    state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered status outputs and the saturating run cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      core_reset_r  <= 1'b1;
      busy_r        <= 1'b0;
      run_done_r    <= 1'b0;
      run_timeout_r <= 1'b0;
      cycle_cnt_r   <= {CYC_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      core_reset_r <= (state_nxt_s != ST_RUN);
      busy_r       <= (state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_RUN);
      if (launch_s) begin
        run_done_r    <= 1'b0;
        run_timeout_r <= 1'b0;
        cycle_cnt_r   <= {CYC_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        if (cycle_cnt_r != {CYC_W{1'b1}}) cycle_cnt_r <= cycle_cnt_r + CYC_W'(1);
        if (core_done)          run_done_r    <= 1'b1;
        else if (timeout_hit_s) run_timeout_r <= 1'b1;
      end
    end
  end

  // Host read port: capture data on a granted read, flag it valid for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rvalid_r <= 1'b0;
      host_rdata_r  <= {DW{1'b0}};
    end else begin
      host_rvalid_r <= host_rd_s;
      if (host_rd_s) host_rdata_r <= mem_rdata;
    end
  end

  run_ctrl_mem_mux #(
    .DW (DW),
    .AW (AW)
  ) u_mem_mux (
    .state      (state_r),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_gnt   (host_gnt_s),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .mem_we     (mem_we_s),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

`ifdef RUN_CTRL_WR_COUNT_EN
  logic [CYC_W-1:0] wr_cnt_r;

  // Count committed core writes during RUN, saturating; cleared on each launch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_r <= {CYC_W{1'b0}};
    end else if (launch_s) begin
      wr_cnt_r <= {CYC_W{1'b0}};
    end else if ((state_r == ST_RUN) && mem_we_s && (wr_cnt_r != {CYC_W{1'b1}})) begin
      wr_cnt_r <= wr_cnt_r + CYC_W'(1);
    end
  end

  assign core_wr_cnt = wr_cnt_r;
`else
  // Write counting is not built in this configuration.
`endif

  assign mem_we      = mem_we_s;
  assign host_gnt    = host_gnt_s;
  assign host_rvalid = host_rvalid_r;
  assign host_rdata  = host_rdata_r;
  assign core_reset  = core_reset_r;
  assign core_rdata  = mem_rdata;
  assign busy        = busy_r;
  assign run_done    = run_done_r;
  assign run_timeout = run_timeout_r;
  assign cycle_cnt   = cycle_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized host/core traffic
// checked against a run-level reference model. Build with RUN_CTRL_WR_COUNT_EN to cover the counter.
`timescale 1ns/1ps
module tb_run_ctrl;

  localparam int MAXC = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = 8'h00;
  logic [7:0]  host_wdata = 8'h00;
  logic        host_gnt, host_rvalid;
  logic [7:0]  host_rdata;
  logic        core_reset;
  logic        core_done = 1'b0;
  logic        core_we = 1'b0;
  logic [7:0]  core_addr = 8'h00;
  logic [7:0]  core_wdata = 8'h00;
  logic [7:0]  core_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        busy, run_done, run_timeout;
  logic [15:0] cycle_cnt;
`ifdef RUN_CTRL_WR_COUNT_EN
  logic [15:0] core_wr_cnt;
`endif

  run_ctrl #(.DW(8), .AW(8), .CYC_W(16), .MAX_CYCLES(16'd8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_reset(core_reset), .core_done(core_done), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .cycle_cnt(cycle_cnt)
`ifdef RUN_CTRL_WR_COUNT_EN
    , .core_wr_cnt(core_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment dat_mem: synchronous write, combinational read.
  logic [7:0] dmem [0:255];
  logic       clr_mem = 1'b1;
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [7:0] exp_mem [0:255];
  logic [7:0] tab_a [0:31];
  logic [7:0] tab_d [0:31];
  int         m_cycles, m_wr;
  logic       m_done;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Observations from drive_run.
  logic obs_launch_busy, obs_launch_rst, obs_launch_memwe, obs_gnt_seen;
  int   obs_run_cycles;

  // A run ends with done in RUN cycle done_at if 1..MAXC, else at the watchdog after MAXC cycles.
  // Core writes commit only in RUN cycles 1..end, in order.
  task automatic model_run(input int done_at, input logic [31:0] mask);
    m_done   = (done_at >= 1) && (done_at <= MAXC);
    m_cycles = m_done ? done_at : MAXC;
    m_wr     = 0;
    for (int k = 1; k <= m_cycles; k++) begin
      if (mask[k]) begin
        exp_mem[tab_a[k]] = tab_d[k];
        m_wr++;
      end
    end
  endtask

  task automatic host_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                           output logic gnt_o, output logic rv_o, output logic [7:0] rd_o);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    #1;
    gnt_o = host_gnt;
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
    rv_o = host_rvalid;
    rd_o = host_rdata;
  endtask

  // Pulses start, drives the core for each RUN cycle k (write if mask[k], done if k==done_at).
  task automatic drive_run(input int done_at, input logic [31:0] mask);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs_launch_busy = busy;
    obs_launch_rst  = core_reset;
    obs_gnt_seen    = 1'b0;
    core_we = mask[0]; core_addr = tab_a[0]; core_wdata = tab_d[0];
    #1;
    obs_launch_memwe = mem_we;
    if (host_gnt === 1'b1) obs_gnt_seen = 1'b1;
    @(posedge clk); #1;
    core_we = 1'b0;
    obs_run_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      if (core_reset !== 1'b0) break;
      obs_run_cycles++;
      core_done = (k == done_at);
      core_we = mask[k]; core_addr = tab_a[k]; core_wdata = tab_d[k];
      #1;
      if (host_gnt === 1'b1) obs_gnt_seen = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0; core_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: got %b expected 1", core_reset); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (run_done !== 1'b0) $display("FAIL rst_run_done: got %b expected 0", run_done); else pass_cnt++;
    chk_cnt++; if (run_timeout !== 1'b0) $display("FAIL rst_run_timeout: got %b expected 0", run_timeout); else pass_cnt++;
    chk_cnt++; if (cycle_cnt !== 16'd0) $display("FAIL rst_cycle_cnt: got %0d expected 0", cycle_cnt); else pass_cnt++;
    chk_cnt++; if (host_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", host_rvalid); else pass_cnt++;
    chk_cnt++; if (host_rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", host_rdata); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", mem_we); else pass_cnt++;
`ifdef RUN_CTRL_WR_COUNT_EN
    chk_cnt++; if (core_wr_cnt !== 16'd0) $display("FAIL rst_wr_cnt: got %0d expected 0", core_wr_cnt); else pass_cnt++;
`endif
    clr_mem = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (core_reset !== 1'b1) $display("FAIL idle_core_reset: got %b expected 1", core_reset); else pass_cnt++;
  endtask

  task automatic test_preload();
    logic g, rv;
    logic [7:0] rd;
    host_xfer(1'b1, 8'h10, 8'hA5, g, rv, rd);
    exp_mem[8'h10] = 8'hA5;
    chk_cnt++; if (g !== 1'b1) $display("FAIL pre_wr_gnt: got %b expected 1", g); else pass_cnt++;
    chk_cnt++; if (rv !== 1'b0) $display("FAIL pre_wr_rvalid: got %b expected 0", rv); else pass_cnt++;
    host_xfer(1'b0, 8'h10, 8'h00, g, rv, rd);
    chk_cnt++; if (g !== 1'b1) $display("FAIL pre_rd_gnt: got %b expected 1", g); else pass_cnt++;
    chk_cnt++; if (rv !== 1'b1) $display("FAIL pre_rd_rvalid: got %b expected 1", rv); else pass_cnt++;
    chk_cnt++; if (rd !== 8'hA5) $display("FAIL pre_rd_data: got %h expected a5", rd); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (host_rvalid !== 1'b0) $display("FAIL pre_rvalid_drop: got %b expected 0", host_rvalid); else pass_cnt++;
    chk_cnt++; if (core_reset !== 1'b1) $display("FAIL pre_core_reset: got %b expected 1", core_reset); else pass_cnt++;
    chk_cnt++; if (core_rdata !== exp_mem[8'h10]) $display("FAIL pre_core_rdata: got %h expected %h", core_rdata, exp_mem[8'h10]); else pass_cnt++;
  endtask

  task automatic test_normal_run();
    logic g, rv;
    logic [7:0] rd;
    tab_a[1] = 8'h20; tab_d[1] = 8'h3C;
    drive_run(5, 32'h2);
    model_run(5, 32'h2);
    chk_cnt++; if (obs_launch_busy !== 1'b1) $display("FAIL run_launch_busy: got %b expected 1", obs_launch_busy); else pass_cnt++;
    chk_cnt++; if (obs_launch_rst !== 1'b1) $display("FAIL run_launch_core_reset: got %b expected 1", obs_launch_rst); else pass_cnt++;
    chk_cnt++; if (obs_run_cycles != 5) $display("FAIL run_cycles: got %0d expected 5", obs_run_cycles); else pass_cnt++;
    chk_cnt++; if (run_done !== 1'b1) $display("FAIL run_done: got %b expected 1", run_done); else pass_cnt++;
    chk_cnt++; if (run_timeout !== 1'b0) $display("FAIL run_timeout: got %b expected 0", run_timeout); else pass_cnt++;
    chk_cnt++; if (cycle_cnt !== 16'd5) $display("FAIL run_cycle_cnt: got %0d expected 5", cycle_cnt); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || core_reset !== 1'b1) $display("FAIL run_exit_flags: got busy=%b core_reset=%b expected 0/1", busy, core_reset); else pass_cnt++;
    host_xfer(1'b0, 8'h20, 8'h00, g, rv, rd);
    chk_cnt++; if (rv !== 1'b1 || rd !== 8'h3C) $display("FAIL run_readback: got rv=%b data=%h expected 1/3c", rv, rd); else pass_cnt++;
  endtask

  task automatic test_stall();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    drive_run(3, 32'h0);
    model_run(3, 32'h0);
    chk_cnt++; if (obs_gnt_seen !== 1'b0) $display("FAIL stall_gnt_busy: got %b expected 0", obs_gnt_seen); else pass_cnt++;
    chk_cnt++; if (run_done !== 1'b1) $display("FAIL stall_run_done: got %b expected 1", run_done); else pass_cnt++;
    chk_cnt++; if (host_gnt !== 1'b1) $display("FAIL stall_gnt_done: got %b expected 1", host_gnt); else pass_cnt++;
    chk_cnt++; if (dmem[8'h30] !== exp_mem[8'h30]) $display("FAIL stall_no_write: got %h expected %h", dmem[8'h30], exp_mem[8'h30]); else pass_cnt++;
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
    exp_mem[8'h30] = 8'h77;
    chk_cnt++; if (dmem[8'h30] !== 8'h77) $display("FAIL stall_write_lands: got %h expected 77", dmem[8'h30]); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    drive_run(0, 32'h0);
    model_run(0, 32'h0);
    chk_cnt++; if (obs_run_cycles != MAXC) $display("FAIL wd_cycles: got %0d expected %0d", obs_run_cycles, MAXC); else pass_cnt++;
    chk_cnt++; if (run_timeout !== 1'b1) $display("FAIL wd_timeout: got %b expected 1", run_timeout); else pass_cnt++;
    chk_cnt++; if (run_done !== 1'b0) $display("FAIL wd_done: got %b expected 0", run_done); else pass_cnt++;
    chk_cnt++; if (cycle_cnt !== 16'd8) $display("FAIL wd_cycle_cnt: got %0d expected 8", cycle_cnt); else pass_cnt++;
  endtask

  task automatic test_done_at_limit();
    tab_a[8] = 8'h40; tab_d[8] = 8'h5A;
    drive_run(MAXC, 32'h100);
    model_run(MAXC, 32'h100);
    chk_cnt++; if (run_done !== 1'b1) $display("FAIL lim_done: got %b expected 1", run_done); else pass_cnt++;
    chk_cnt++; if (run_timeout !== 1'b0) $display("FAIL lim_timeout: got %b expected 0", run_timeout); else pass_cnt++;
    chk_cnt++; if (cycle_cnt !== 16'd8) $display("FAIL lim_cycle_cnt: got %0d expected 8", cycle_cnt); else pass_cnt++;
    chk_cnt++; if (dmem[8'h40] !== 8'h5A) $display("FAIL lim_last_write: got %h expected 5a", dmem[8'h40]); else pass_cnt++;
  endtask

  task automatic test_priority();
    start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 8'hFF;
    #1;
    chk_cnt++; if (host_gnt !== 1'b0) $display("FAIL prio_gnt: got %b expected 0", host_gnt); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL prio_mem_we: got %b expected 0", mem_we); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0; host_req = 1'b0; host_we = 1'b0;
    chk_cnt++; if (busy !== 1'b1 || core_reset !== 1'b1) $display("FAIL prio_launch: got busy=%b core_reset=%b expected 1/1", busy, core_reset); else pass_cnt++;
    chk_cnt++; if (dmem[8'h00] !== exp_mem[8'h00]) $display("FAIL prio_mem_kept: got %h expected %h", dmem[8'h00], exp_mem[8'h00]); else pass_cnt++;
    @(posedge clk); #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk_cnt++; if (run_done !== 1'b1 || cycle_cnt !== 16'd1) $display("FAIL prio_finish: got done=%b cnt=%0d expected 1/1", run_done, cycle_cnt); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic g, rv;
    logic [7:0] rd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    core_we = 1'b1; core_addr = 8'h50; core_wdata = 8'hC3;
    @(posedge clk); #1;
    core_we = 1'b0;
    exp_mem[8'h50] = 8'hC3;
    chk_cnt++; if (core_reset !== 1'b0) $display("FAIL abort_in_run: got core_reset=%b expected 0", core_reset); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (core_reset !== 1'b1) $display("FAIL abort_core_reset: got %b expected 1", core_reset); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || cycle_cnt !== 16'd0) $display("FAIL abort_state: got busy=%b cnt=%0d expected 0/0", busy, cycle_cnt); else pass_cnt++;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (dmem[8'h50] !== 8'hC3) $display("FAIL abort_mem_kept: got %h expected c3", dmem[8'h50]); else pass_cnt++;
    host_xfer(1'b0, 8'h50, 8'h00, g, rv, rd);
    chk_cnt++; if (g !== 1'b1 || rd !== 8'hC3) $display("FAIL abort_readback: got gnt=%b data=%h expected 1/c3", g, rd); else pass_cnt++;
  endtask

  task automatic test_wr_count();
`ifdef RUN_CTRL_WR_COUNT_EN
    tab_a[0] = 8'h6F; tab_d[0] = 8'hEE;
    tab_a[1] = 8'h60; tab_d[1] = 8'h11;
    tab_a[2] = 8'h61; tab_d[2] = 8'h22;
    tab_a[3] = 8'h62; tab_d[3] = 8'h33;
    drive_run(5, 32'hF);
    model_run(5, 32'hF);
    chk_cnt++; if (core_wr_cnt !== 16'(m_wr)) $display("FAIL wrc_count: got %0d expected %0d", core_wr_cnt, m_wr); else pass_cnt++;
    chk_cnt++; if (obs_launch_memwe !== 1'b0) $display("FAIL wrc_launch_we: got %b expected 0", obs_launch_memwe); else pass_cnt++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_cnt++; if (core_wr_cnt !== 16'd0) $display("FAIL wrc_clear: got %0d expected 0", core_wr_cnt); else pass_cnt++;
    @(posedge clk); #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
`else
    // Counter absent in this build; nothing to exercise.
`endif
  endtask

  task automatic test_random();
    logic g, rv, we;
    logic [7:0] a, d, rd;
    logic [31:0] mask;
    int n, done_at, bad;
    for (int it = 0; it < 30; it++) begin
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        we = 1'($urandom_range(0, 1));
        a  = 8'($urandom);
        d  = 8'($urandom);
        host_xfer(we, a, d, g, rv, rd);
        chk_cnt++; if (g !== 1'b1) $display("FAIL rand_host_gnt: got %b expected 1", g); else pass_cnt++;
        if (we) begin
          exp_mem[a] = d;
        end else begin
          chk_cnt++; if (rv !== 1'b1 || rd !== exp_mem[a]) $display("FAIL rand_host_read: addr %h got rv=%b data=%h expected 1/%h", a, rv, rd, exp_mem[a]); else pass_cnt++;
        end
      end
      for (int k = 0; k < 32; k++) begin
        tab_a[k] = 8'($urandom);
        tab_d[k] = 8'($urandom);
      end
      mask    = $urandom;
      done_at = int'($urandom_range(0, 10));
      drive_run(done_at, mask);
      model_run(done_at, mask);
      chk_cnt++; if (obs_run_cycles != m_cycles) $display("FAIL rand_run_cycles: got %0d expected %0d", obs_run_cycles, m_cycles); else pass_cnt++;
      chk_cnt++; if (run_done !== m_done || run_timeout !== !m_done) $display("FAIL rand_status: got done=%b timeout=%b expected %b/%b", run_done, run_timeout, m_done, !m_done); else pass_cnt++;
      chk_cnt++; if (cycle_cnt !== 16'(m_cycles)) $display("FAIL rand_cycle_cnt: got %0d expected %0d", cycle_cnt, m_cycles); else pass_cnt++;
`ifdef RUN_CTRL_WR_COUNT_EN
      chk_cnt++; if (core_wr_cnt !== 16'(m_wr)) $display("FAIL rand_wr_cnt: got %0d expected %0d", core_wr_cnt, m_wr); else pass_cnt++;
`endif
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dmem[i] !== exp_mem[i]) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL rand_mem_image: got %0d differing words expected 0", bad); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      tab_a[i] = 8'h00;
      tab_d[i] = 8'h00;
    end
    test_reset();
    test_preload();
    test_normal_run();
    test_stall();
    test_watchdog();
    test_done_at_limit();
    test_priority();
    test_abort();
    test_wr_count();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
